// File: rtl/regfile_pkg.sv
// Shared definitions for the register file / scoreboard block.
//   DATA_W_DEF, ADDR_W_DEF : default register width and address width
//   ZERO_ADDR              : address of the hardwired zero register
//   port_lo()              : low bit of port k inside a flattened multi-port bus
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;

    // Port k of a bus packed as {port N-1, ..., port 1, port 0} starts at k*w.
    function automatic int port_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
//   rd_addr_i  : register selected by this port
//   mem_i      : full register array contents
//   busy_i     : full pending (busy) vector
//   wr_en_i / wr_addr_i / wr_data_i : writeback in flight this cycle
//   rd_data_o  : read data (zero register, then bypass, then storage)
//   rd_busy_o  : selected register still waits for its producer
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]                       rd_addr_i,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]      mem_i,
    input  logic [(1<<ADDR_W)-1:0]                  busy_i,
    input  logic                                    wr_en_i,
    input  logic [ADDR_W-1:0]                       wr_addr_i,
    input  logic [DATA_W-1:0]                       wr_data_i,
    output logic [DATA_W-1:0]                       rd_data_o,
    output logic                                    rd_busy_o
);

    logic wr_hit_s;
    logic is_zero_s;

    // Decode: does this read target the zero register or the register being written now?
    always_comb begin
        wr_hit_s  = wr_en_i && (wr_addr_i == rd_addr_i);
        is_zero_s = (ZERO_REG != 0) && (rd_addr_i == ADDR_W'(ZERO_ADDR));
    end

    // Data and busy select; the zero register overrides the bypass, and a value
    // forwarded this cycle also resolves the pending hazard.
    always_comb begin
        if (is_zero_s) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end else if ((BYPASS != 0) && wr_hit_s) begin
            rd_data_o = wr_data_i;
            rd_busy_o = 1'b0;
        end else begin
            rd_data_o = mem_i[rd_addr_i];
            rd_busy_o = busy_i[rd_addr_i];
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending scoreboard for the pipelined datapath.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   rd_addr_i / rd_data_o   : NUM_RD combinational read ports (flattened, port 0 in LSBs)
//   rd_busy_o               : per-port "register has an outstanding producer"
//   wr_en_i/addr/data       : writeback port; also clears the written register's busy bit
//   alloc_en_i/alloc_addr_i : issue marks a destination register pending
//   alloc_stall_o           : allocation target already pending (WAW hazard)
//   flush_i                 : clears all pending bits
//   busy_cnt_o              : registered count of pending registers
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     alloc_en_i,
    input  logic [ADDR_W-1:0]        alloc_addr_i,
    output logic                     alloc_stall_o,
    input  logic                     flush_i,
    output logic [ADDR_W:0]          busy_cnt_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0]             busy_q;
    logic [DEPTH-1:0]             busy_d;
    logic [ADDR_W:0]              cnt_q;
    logic [ADDR_W:0]              cnt_d;
    logic                         wr_ok_s;

    // Writes to the hardwired zero register are dropped.
    always_comb begin
        if ((ZERO_REG != 0) && (wr_addr_i == ADDR_W'(ZERO_ADDR))) begin
            wr_ok_s = 1'b0;
        end else begin
            wr_ok_s = wr_en_i;
        end
    end

    // Register storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else if (wr_ok_s) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    // Scoreboard next state: a new producer beats flush, flush beats writeback.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (alloc_en_i && (alloc_addr_i == ADDR_W'(r)) &&
                !((ZERO_REG != 0) && (r == ZERO_ADDR))) begin
                busy_d[r] = 1'b1;
            end else if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (wr_en_i && (wr_addr_i == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
    end

    // Population count of the next busy vector, so the registered count lines
    // up with the busy bits it describes.
    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[r]};
        end
    end

    // Scoreboard and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // WAW stall; a same-cycle writeback or flush frees the target first.
    always_comb begin
        alloc_stall_o = alloc_en_i && busy_q[alloc_addr_i] &&
                        !(wr_en_i && (wr_addr_i == alloc_addr_i)) && !flush_i;
    end

    assign busy_cnt_o = cnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        localparam int ALO = port_lo(k, ADDR_W);
        localparam int DLO = port_lo(k, DATA_W);

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .rd_addr_i (rd_addr_i[ALO +: ADDR_W]),
            .mem_i     (mem_q),
            .busy_i    (busy_q),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .rd_data_o (rd_data_o[DLO +: DATA_W]),
            .rd_busy_o (rd_busy_o[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (DATA_W=32, ADDR_W=5, NUM_RD=2,
// ZERO_REG=1, BYPASS=1): directed vector table plus randomized cycles checked
// against an array-based reference model.
module tb_regfile_scoreboard;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra0, ra1;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ae;
    logic [4:0]  aa;
    logic        stall;
    logic        fl;
    logic [5:0]  cnt;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rd_addr_i     ({ra1, ra0}),
        .rd_data_o     (rd_data),
        .rd_busy_o     (rd_busy),
        .wr_en_i       (we),
        .wr_addr_i     (wa),
        .wr_data_i     (wd),
        .alloc_en_i    (ae),
        .alloc_addr_i  (aa),
        .alloc_stall_o (stall),
        .flush_i       (fl),
        .busy_cnt_o    (cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_busy[DEPTH];

    function automatic int m_count();
        int s = 0;
        for (int i = 0; i < DEPTH; i++) s += int'(m_busy[i]);
        return s;
    endfunction

    function automatic logic [31:0] e_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic bit e_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (we && wa == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit e_stall(input bit en, input logic [4:0] a);
        return en && m_busy[a] && !(we && wa == a) && !fl;
    endfunction

    // Apply the current inputs to the model as the clock edge does:
    // writeback clears, flush clears everything, then a new producer sets.
    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = 32'd0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && wa != 5'd0) m_mem[wa] = wd;
            if (we) m_busy[wa] = 1'b0;
            if (fl) for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            if (ae && aa != 5'd0) m_busy[aa] = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_d0"},  rd_data[31:0],  e_data(ra0));
        check({tag, "_d1"},  rd_data[63:32], e_data(ra1));
        check({tag, "_b0"},  32'(rd_busy[0]), 32'(e_busy(ra0)));
        check({tag, "_b1"},  32'(rd_busy[1]), 32'(e_busy(ra1)));
        check({tag, "_st"},  32'(stall),      32'(e_stall(ae, aa)));
        check({tag, "_cnt"}, 32'(cnt),        32'(m_count()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; wa = 5'd0; wd = 32'd0;
        ae = 1'b0; aa = 5'd0; fl = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          ae;
        logic [4:0]  aa;
        bit          fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          b0;
        bit          b1;
        bit          st;
        logic [5:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input bit r, input bit w, input logic [4:0] a_w, input logic [31:0] d_w,
        input bit al, input logic [4:0] a_a, input bit f,
        input logic [4:0] r0, input logic [4:0] r1,
        input logic [31:0] x0, input logic [31:0] x1,
        input bit y0, input bit y1, input bit s, input logic [5:0] c);
        vec_t v;
        v.rst = r; v.we = w; v.wa = a_w; v.wd = d_w; v.ae = al; v.aa = a_a; v.fl = f;
        v.ra0 = r0; v.ra1 = r1; v.d0 = x0; v.d1 = x1; v.b0 = y0; v.b1 = y1;
        v.st = s; v.cnt = c;
        return v;
    endfunction

    initial begin
        logic [4:0] cand;
        bit         want;

        idle();
        rst = 1'b1; ra0 = 5'd0; ra1 = 5'd0;
        tick();
        rst = 1'b0;

        // Reset then read every register: all zero, nothing busy.
        for (int i = 0; i < DEPTH / 2; i++) begin
            idle();
            ra0 = 5'(2 * i); ra1 = 5'(2 * i + 1);
            #3;
            check("rst_d0", rd_data[31:0], 32'd0);
            check("rst_d1", rd_data[63:32], 32'd0);
            check("rst_busy", 32'(rd_busy), 32'd0);
            check("rst_cnt", 32'(cnt), 32'd0);
            tick();
        end

        //            rst we wa     wd            ae aa     fl ra0    ra1    d0            d1            b0 b1 st cnt
        tbl.push_back(mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0,  0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 6'd0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 6'd0));
        tbl.push_back(mk(0, 1, 5'd5, 32'h12345678, 0, 5'd0,  0, 5'd5,  5'd5,  32'h12345678, 32'h12345678, 0, 0, 0, 6'd0));
        tbl.push_back(mk(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0,  0, 5'd0,  5'd0,  32'h0,        32'h0,        0, 0, 0, 6'd0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd0,  5'd5,  32'h0,        32'h12345678, 0, 0, 0, 6'd0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        1, 5'd7,  0, 5'd7,  5'd5,  32'h0,        32'h12345678, 0, 0, 0, 6'd0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd7,  5'd7,  32'h0,        32'h0,        1, 1, 0, 6'd1));
        tbl.push_back(mk(0, 1, 5'd7, 32'h00000077, 0, 5'd0,  0, 5'd7,  5'd7,  32'h77,       32'h77,       0, 0, 0, 6'd1));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd7,  5'd7,  32'h77,       32'h77,       0, 0, 0, 6'd0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        1, 5'd9,  0, 5'd9,  5'd7,  32'h0,        32'h77,       0, 0, 0, 6'd0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        1, 5'd9,  0, 5'd9,  5'd9,  32'h0,        32'h0,        1, 1, 1, 6'd1));
        tbl.push_back(mk(0, 1, 5'd9, 32'h00000099, 1, 5'd9,  0, 5'd9,  5'd0,  32'h99,       32'h0,        0, 0, 0, 6'd1));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd9,  5'd9,  32'h99,       32'h99,       1, 1, 0, 6'd1));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        1, 5'd4,  0, 5'd4,  5'd9,  32'h0,        32'h99,       0, 1, 0, 6'd1));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd4,  5'd9,  32'h0,        32'h99,       1, 1, 0, 6'd2));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        1, 5'd3,  1, 5'd3,  5'd4,  32'h0,        32'h0,        0, 1, 0, 6'd2));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd3,  5'd9,  32'h0,        32'h99,       1, 0, 0, 6'd1));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        1, 5'd10, 0, 5'd3,  5'd10, 32'h0,        32'h0,        1, 0, 0, 6'd1));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        1, 5'd11, 0, 5'd10, 5'd11, 32'h0,        32'h0,        1, 0, 0, 6'd2));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        1, 5'd12, 0, 5'd11, 5'd12, 32'h0,        32'h0,        1, 0, 0, 6'd3));
        tbl.push_back(mk(0, 1, 5'd2, 32'h00002222, 0, 5'd0,  0, 5'd12, 5'd2,  32'h0,        32'h2222,     1, 0, 0, 6'd4));
        tbl.push_back(mk(1, 1, 5'd2, 32'h0000ABCD, 1, 5'd13, 0, 5'd2,  5'd12, 32'hABCD,     32'h0,        0, 1, 0, 6'd4));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd2,  5'd3,  32'h0,        32'h0,        0, 0, 0, 6'd0));
        tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0,  0, 5'd10, 5'd13, 32'h0,        32'h0,        0, 0, 0, 6'd0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
            ae = tbl[i].ae; aa = tbl[i].aa; fl = tbl[i].fl;
            ra0 = tbl[i].ra0; ra1 = tbl[i].ra1;
            #3;
            check($sformatf("vec%0d_d0", i), rd_data[31:0], tbl[i].d0);
            check($sformatf("vec%0d_d1", i), rd_data[63:32], tbl[i].d1);
            check($sformatf("vec%0d_b0", i), 32'(rd_busy[0]), 32'(tbl[i].b0));
            check($sformatf("vec%0d_b1", i), 32'(rd_busy[1]), 32'(tbl[i].b1));
            check($sformatf("vec%0d_st", i), 32'(stall), 32'(tbl[i].st));
            check($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(tbl[i].cnt));
            tick();
        end

        // Randomized traffic on a 16-register window to force collisions.
        // Allocation is only issued when not stalled, as upstream must behave.
        for (int i = 0; i < 600; i++) begin
            idle();
            rst = ($urandom_range(0, 79) == 0);
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 15));
            wd  = $urandom;
            fl  = ($urandom_range(0, 19) == 0);
            cand = 5'($urandom_range(0, 15));
            want = ($urandom_range(0, 2) != 0);
            aa  = cand;
            ae  = want && !e_stall(1'b1, cand);
            ra0 = 5'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 15));
            #3;
            check_model("rnd");
            if (want) check("alloc_legal", 32'(stall), 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised register file for the pipelined CPU datapath.
- Provides NUM_RD combinational read ports and one synchronous write port, with optional same-cycle write-to-read bypass and optional hardwired zero register.
- Holds a per-register pending (busy) scoreboard: set when the decode stage issues an instruction that writes the register, cleared at writeback.
- Feeds the hazard unit, so RAW stalls are decided without comparing pipeline-stage addresses.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never becomes busy
BYPASS, 1, 1 = a write in the current cycle is forwarded to matching reads in the same cycle

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous reset, active-high
rd_addr_i  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data_o  output  NUM_RD*DATA_W  read data per port, combinational
rd_busy_o  output  NUM_RD  read register has an outstanding producer, combinational
wr_en_i  input  1  writeback enable
wr_addr_i  input  ADDR_W  writeback address
wr_data_i  input  DATA_W  writeback data
alloc_en_i  input  1  issue marks a destination register pending
alloc_addr_i  input  ADDR_W  destination register being allocated
alloc_stall_o  output  1  allocation target is already pending (WAW); issue must hold
flush_i  input  1  clears all pending bits (pipeline flush)
busy_cnt_o  output  ADDR_W+1  number of registers currently pending, registered

Behaviour:
Reset:
- rst_i=1 at a rising edge clears all registers to 0, all busy bits, and busy_cnt_o.
- Reset has priority over wr_en_i, alloc_en_i and flush_i in the same cycle.
- Combinational outputs reflect the cleared state from the following cycle.

Read (zero latency):
- rd_data_o[k] = mem[rd_addr[k]].
- If BYPASS=1, wr_en_i=1 and wr_addr_i==rd_addr[k]: rd_data_o[k]=wr_data_i.
- ZERO_REG=1 and rd_addr[k]==0: rd_data_o[k]=0, overriding the bypass.

Write:
- At the rising edge with wr_en_i=1: mem[wr_addr_i] <= wr_data_i.
- The write is suppressed when ZERO_REG=1 and wr_addr_i==0.
- Writing a non-busy register is legal and updates the data only.

Scoreboard, per register r, next-state priority (highest first):
1. rst_i -> 0
2. alloc_en_i && alloc_addr_i==r && !(ZERO_REG && r==0) -> 1. A new producer wins over a same-cycle writeback and over flush.
3. flush_i -> 0
4. wr_en_i && wr_addr_i==r -> 0
5. otherwise hold

Combinational scoreboard outputs:
- rd_busy_o[k] = busy[rd_addr[k]] && !(wr_en_i && wr_addr_i==rd_addr[k]). A value arriving this cycle resolves the hazard when BYPASS=1.
- If BYPASS=0, rd_busy_o[k] = busy[rd_addr[k]].
- rd_busy_o[k] is always 0 for the zero register.
- alloc_stall_o = alloc_en_i && busy[alloc_addr_i] && !(wr_en_i && wr_addr_i==alloc_addr_i) && !flush_i.
- When alloc_stall_o=1 the block still applies the allocation. Upstream must not assert alloc_en_i while it is stalled; the bench checks this as an assertion.

busy_cnt_o:
- Registered population count of the busy vector; it updates the cycle after a busy-bit change.
- Range 0..2**ADDR_W, with no wrap.

Decomposition:
- Package regfile_pkg holds the default DATA_W and ADDR_W, the ZERO_ADDR constant (0), and the helper function for extracting a port slice.
- One sub-module, regfile_read_port: address decode, bypass mux and busy mask for a single port.
- The top level instantiates regfile_read_port NUM_RD times in a generate loop. Storage, scoreboard and counter stay in the top level.

Test Plan:
1. Reset then read: rst_i=1 for 1 cycle; read all 32 addresses -> rd_data_o=0, rd_busy_o=0, busy_cnt_o=0.
2. Write then read: write 0xDEADBEEF to r5; next cycle read r5 on both ports -> 0xDEADBEEF. Same-cycle write of 0x12345678 to r5 while reading r5 -> 0x12345678 (BYPASS=1), or 0xDEADBEEF (BYPASS=0).
3. Zero register: write 0xFFFFFFFF to r0 and alloc r0 -> rd_data_o=0, rd_busy_o=0, busy_cnt_o unchanged.
4. Scoreboard: alloc r7 -> next cycle rd_busy_o=1, busy_cnt_o=1. Writeback r7 -> rd_busy_o=0 in that same cycle; busy_cnt_o=0 the cycle after.
5. Collisions:
   - Alloc r9 while r9 is busy -> alloc_stall_o=1.
   - Alloc r9 together with a writeback to r9 -> alloc_stall_o=0 and r9 stays busy.
   - Alloc r3 together with flush_i -> only r3 is busy afterwards, busy_cnt_o=1.
6. Reset mid-operation: 4 registers busy and wr_en_i=1 to r2 in the reset cycle -> all busy bits clear, r2 reads 0, busy_cnt_o=0 the next cycle.
